// File: rtl/arf_ctrl_pkg.sv
// Shared codes for the address register file controller: register-file control
// encodings, execute opcodes and the sequencer state set.
package arf_ctrl_pkg;

    localparam logic [2:0] FS_DEC   = 3'b000;
    localparam logic [2:0] FS_INC   = 3'b001;
    localparam logic [2:0] FS_LOAD  = 3'b010;
    localparam logic [2:0] FS_CLEAR = 3'b011;

    // RegSel is active-low: bit2 PC, bit1 AR, bit0 SP
    localparam logic [2:0] RS_PC_EN = 3'b011;
    localparam logic [2:0] RS_AR_EN = 3'b101;
    localparam logic [2:0] RS_SP_EN = 3'b110;
    localparam logic [2:0] RS_NONE  = 3'b111;
    localparam logic [2:0] RS_ALL   = 3'b000;

    localparam logic [1:0] OS_PC = 2'b00;
    localparam logic [1:0] OS_AR = 2'b10;
    localparam logic [1:0] OS_SP = 2'b11;

    localparam logic [2:0] XOP_PUSH = 3'b000;
    localparam logic [2:0] XOP_POP  = 3'b001;
    localparam logic [2:0] XOP_JUMP = 3'b010;
    localparam logic [2:0] XOP_LDAR = 3'b011;

    localparam int STREAK_W = 2;

    typedef enum logic [3:0] {
        S_INIT,
        S_IDLE,
        S_F1,
        S_F2,
        S_PSH_DEC,
        S_PSH_WR,
        S_POP_RD,
        S_POP_INC,
        S_JMP,
        S_LDAR,
        S_XNOP
    } state_t;

    // First state of the sequence that executes a granted x_op
    function automatic state_t x_entry(input logic [2:0] op);
        case (op)
            XOP_PUSH: return S_PSH_DEC;
            XOP_POP:  return S_POP_RD;
            XOP_JUMP: return S_JMP;
            XOP_LDAR: return S_LDAR;
            default:  return S_XNOP;
        endcase
    endfunction

endpackage

// File: rtl/arf_arbiter.sv
// IDLE-cycle grant decision between fetch and execute, with a bounded
// execute streak so a waiting fetch is never starved.
module arf_arbiter
    import arf_ctrl_pkg::*;
#(
    parameter int STREAK_MAX = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic f_req,
    input  logic x_req,
    input  logic idle,
    output logic grant_f,
    output logic grant_x
);

    localparam logic [STREAK_W-1:0] STREAK_CAP = STREAK_W'(STREAK_MAX);

    logic [STREAK_W-1:0] streak;
    logic                fetch_due;

    assign fetch_due = f_req && (streak == STREAK_CAP);
    assign grant_x   = idle && x_req && !fetch_due;
    assign grant_f   = idle && f_req && !grant_x;

    // Streak only moves in IDLE; execute grants count only while fetch waits
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            streak <= '0;
        end else if (idle) begin
            if (grant_f || !f_req) begin
                streak <= '0;
            end else if (grant_x && (streak != STREAK_CAP)) begin
                streak <= streak + 1'b1;
            end
        end
    end

endmodule

// File: rtl/arf_controller.sv
// Sequencer for the PC/AR/SP address register file: arbitrates fetch and
// execute requests and drives the file's controls as a Moore decode of state.
module arf_controller
    import arf_ctrl_pkg::*;
#(
    parameter int STREAK_MAX = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       f_req,
    input  logic       x_req,
    input  logic [2:0] x_op,
    output logic [2:0] FunSel,
    output logic [2:0] RegSel,
    output logic [1:0] OutCSel,
    output logic [1:0] OutDSel,
    output logic       addr_vld,
    output logic       f_done,
    output logic       x_done,
    output logic       busy
);

    state_t state;
    state_t state_next;
    logic   grant_f;
    logic   grant_x;

    arf_arbiter #(
        .STREAK_MAX(STREAK_MAX)
    ) u_arbiter (
        .clk    (clk),
        .rst    (rst),
        .f_req  (f_req),
        .x_req  (x_req),
        .idle   (state == S_IDLE),
        .grant_f(grant_f),
        .grant_x(grant_x)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_INIT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_INIT:    state_next = S_IDLE;
            S_IDLE: begin
                if (grant_x) begin
                    state_next = x_entry(x_op);
                end else if (grant_f) begin
                    state_next = S_F1;
                end
            end
            S_F1:      state_next = S_F2;
            S_PSH_DEC: state_next = S_PSH_WR;
            S_POP_RD:  state_next = S_POP_INC;
            S_F2,
            S_PSH_WR,
            S_POP_INC,
            S_JMP,
            S_LDAR,
            S_XNOP:    state_next = S_IDLE;
            default:   state_next = S_INIT;
        endcase
    end

    assign OutCSel = 2'b00;
    assign busy    = (state != S_IDLE);

    // OutD always shows the pre-update register: updates land on the closing edge
    always_comb begin
        FunSel   = FS_DEC;
        RegSel   = RS_NONE;
        OutDSel  = OS_PC;
        addr_vld = 1'b0;
        f_done   = 1'b0;
        x_done   = 1'b0;
        case (state)
            S_INIT: begin
                RegSel = RS_ALL;
                FunSel = FS_CLEAR;
            end
            S_F1: begin
                OutDSel  = OS_PC;
                addr_vld = 1'b1;
                RegSel   = RS_PC_EN;
                FunSel   = FS_INC;
            end
            S_F2: begin
                OutDSel  = OS_PC;
                addr_vld = 1'b1;
                RegSel   = RS_PC_EN;
                FunSel   = FS_INC;
                f_done   = 1'b1;
            end
            S_PSH_DEC: begin
                RegSel = RS_SP_EN;
                FunSel = FS_DEC;
            end
            S_PSH_WR: begin
                OutDSel  = OS_SP;
                addr_vld = 1'b1;
                x_done   = 1'b1;
            end
            S_POP_RD: begin
                OutDSel  = OS_SP;
                addr_vld = 1'b1;
            end
            S_POP_INC: begin
                RegSel = RS_SP_EN;
                FunSel = FS_INC;
                x_done = 1'b1;
            end
            S_JMP: begin
                RegSel = RS_PC_EN;
                FunSel = FS_LOAD;
                x_done = 1'b1;
            end
            S_LDAR: begin
                RegSel = RS_AR_EN;
                FunSel = FS_LOAD;
                x_done = 1'b1;
            end
            S_XNOP: begin
                x_done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_arf_controller.sv
// Scoreboard bench for arf_controller driving a behavioural address register file.
module tb_arf_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        f_req = 1'b0;
    logic        x_req = 1'b0;
    logic [2:0]  x_op = 3'd7;
    logic [2:0]  FunSel;
    logic [2:0]  RegSel;
    logic [1:0]  OutCSel;
    logic [1:0]  OutDSel;
    logic        addr_vld;
    logic        f_done;
    logic        x_done;
    logic        busy;

    logic [15:0] pc_r, ar_r, sp_r, out_d;
    logic [15:0] i_val = 16'h0;
    logic [15:0] mpc, mar, msp;
    logic        mon_en = 1'b1;

    int vectors = 0;
    int errs = 0;

    typedef struct packed {
        logic        av;
        logic [15:0] a;
        logic        fd;
        logic        xd;
    } ev_t;

    ev_t expq[$];
    ev_t obs_m, exp_m;

    arf_controller dut (
        .clk     (clk),
        .rst     (rst),
        .f_req   (f_req),
        .x_req   (x_req),
        .x_op    (x_op),
        .FunSel  (FunSel),
        .RegSel  (RegSel),
        .OutCSel (OutCSel),
        .OutDSel (OutDSel),
        .addr_vld(addr_vld),
        .f_done  (f_done),
        .x_done  (x_done),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] rf_fn(input logic [2:0] fs, input logic [15:0] v,
                                          input logic [15:0] imm);
        case (fs)
            3'b000:  return v - 16'd1;
            3'b001:  return v + 16'd1;
            3'b010:  return imm;
            3'b011:  return 16'h0000;
            default: return v;
        endcase
    endfunction

    // Address register file stand-in
    always @(posedge clk) begin
        if (!RegSel[2]) pc_r <= rf_fn(FunSel, pc_r, i_val);
        if (!RegSel[1]) ar_r <= rf_fn(FunSel, ar_r, i_val);
        if (!RegSel[0]) sp_r <= rf_fn(FunSel, sp_r, i_val);
    end

    always_comb begin
        case (OutDSel)
            2'b11:   out_d = sp_r;
            2'b10:   out_d = ar_r;
            default: out_d = pc_r;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic ev_t mk(input logic av, input logic [15:0] a, input logic fd,
                               input logic xd);
        ev_t e;
        e.av = av; e.a = a; e.fd = fd; e.xd = xd;
        return e;
    endfunction

    // Monitor: every cycle with an address strobe or done pulse is one event
    always @(negedge clk) begin
        if (mon_en && !rst && (addr_vld || f_done || x_done)) begin
            obs_m = mk(addr_vld, addr_vld ? out_d : 16'h0, f_done, x_done);
            if (expq.size() == 0) begin
                chk("unexpected_event", 32'(obs_m), 32'(0));
            end else begin
                exp_m = expq.pop_front();
                chk("event", 32'(obs_m), 32'(exp_m));
            end
        end
    end

    // Reference model: architectural effect and bus activity of each operation
    task automatic model_f();
        expq.push_back(mk(1'b1, mpc, 1'b0, 1'b0));
        expq.push_back(mk(1'b1, mpc + 16'd1, 1'b1, 1'b0));
        mpc = mpc + 16'd2;
    endtask

    task automatic model_x(input logic [2:0] op, input logic [15:0] imm);
        case (op)
            3'd0: begin
                msp = msp - 16'd1;
                expq.push_back(mk(1'b1, msp, 1'b0, 1'b1));
            end
            3'd1: begin
                expq.push_back(mk(1'b1, msp, 1'b0, 1'b0));
                expq.push_back(mk(1'b0, 16'h0, 1'b0, 1'b1));
                msp = msp + 16'd1;
            end
            3'd2: begin
                mpc = imm;
                expq.push_back(mk(1'b0, 16'h0, 1'b0, 1'b1));
            end
            3'd3: begin
                mar = imm;
                expq.push_back(mk(1'b0, 16'h0, 1'b0, 1'b1));
            end
            default: expq.push_back(mk(1'b0, 16'h0, 1'b0, 1'b1));
        endcase
    endtask

    task automatic chk_regs(input string tag);
        chk({tag, "_pc"}, 32'(pc_r), 32'(mpc));
        chk({tag, "_ar"}, 32'(ar_r), 32'(mar));
        chk({tag, "_sp"}, 32'(sp_r), 32'(msp));
    endtask

    task automatic chk_init_outputs();
        chk("init_regsel", 32'(RegSel), 32'(3'b000));
        chk("init_funsel", 32'(FunSel), 32'(3'b011));
        chk("init_outcsel", 32'(OutCSel), 32'(2'b00));
        chk("init_outdsel", 32'(OutDSel), 32'(2'b00));
        chk("init_addr_vld", 32'(addr_vld), 32'(0));
        chk("init_dones", 32'({f_done, x_done}), 32'(0));
        chk("init_busy", 32'(busy), 32'(1));
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b1;
        f_req = 1'b0;
        x_req = 1'b0;
        repeat (2) @(negedge clk);
        chk_init_outputs();
        mpc = 16'h0; mar = 16'h0; msp = 16'h0;
        chk_regs("reset");
        rst = 1'b0;
    endtask

    task automatic run_op(input logic do_f, input logic do_x, input logic [2:0] op,
                          input logic [15:0] imm);
        logic pend_f, pend_x;
        int cyc;
        @(negedge clk);
        if (do_x) model_x(op, imm);
        if (do_f) model_f();
        i_val = imm;
        x_op  = op;
        x_req = do_x;
        f_req = do_f;
        pend_f = do_f;
        pend_x = do_x;
        cyc = 0;
        while ((pend_f || pend_x) && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (x_done && pend_x) begin
                if (op > 3'd3) begin
                    chk("xnop_regsel", 32'(RegSel), 32'(3'b111));
                    chk("xnop_funsel", 32'(FunSel), 32'(3'b000));
                end
                x_req = 1'b0;
                pend_x = 1'b0;
            end
            if (f_done && pend_f) begin
                f_req = 1'b0;
                pend_f = 1'b0;
            end
        end
        if (pend_f || pend_x) chk("done_timeout", 32'({pend_f, pend_x}), 32'(0));
        f_req = 1'b0;
        x_req = 1'b0;
        @(negedge clk);
        chk("idle_busy", 32'(busy), 32'(0));
        chk_regs("op");
    endtask

    task automatic run_streak();
        int st, cnt, cyc;
        @(negedge clk);
        st = 0;
        for (int k = 0; k < 8; k++) begin
            if (st == 3) begin
                model_f();
                st = 0;
            end else begin
                model_x(3'd7, 16'h0);
                st++;
            end
        end
        x_op = 3'd7;
        x_req = 1'b1;
        f_req = 1'b1;
        cnt = 0;
        cyc = 0;
        while (cnt < 8 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (x_done || f_done) begin
                chk("both_done", 32'(x_done && f_done), 32'(0));
                cnt++;
                if (cnt == 8) begin
                    x_req = 1'b0;
                    f_req = 1'b0;
                end
            end
        end
        if (cnt < 8) chk("streak_timeout", 32'(cnt), 32'(8));
        x_req = 1'b0;
        f_req = 1'b0;
        @(negedge clk);
        chk_regs("streak");
    endtask

    task automatic run_reset_mid_push();
        int cyc;
        reset_dut();
        mon_en = 1'b0;
        @(negedge clk);
        x_op = 3'd0;
        x_req = 1'b1;
        cyc = 0;
        while (!addr_vld && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk("pshwr_addr_vld", 32'(addr_vld), 32'(1));
        chk("pshwr_outd", 32'(out_d), 32'(16'hFFFF));
        chk("pshwr_sp", 32'(sp_r), 32'(16'hFFFF));
        #2 rst = 1'b1;
        #1 chk_init_outputs();
        x_req = 1'b0;
        @(posedge clk);
        #1;
        mpc = 16'h0; mar = 16'h0; msp = 16'h0;
        chk_regs("midreset");
        @(negedge clk);
        rst = 1'b0;
        mon_en = 1'b1;
    endtask

    initial begin
        reset_dut();
        run_op(1'b1, 1'b0, 3'd7, 16'h0);           // fetch from 0
        reset_dut();
        run_op(1'b0, 1'b1, 3'd0, 16'h0);           // push: SP wraps to FFFF
        run_op(1'b0, 1'b1, 3'd1, 16'h0);           // pop back to 0
        run_op(1'b0, 1'b1, 3'd2, 16'h1234);        // jump
        run_op(1'b1, 1'b0, 3'd7, 16'h0);           // fetch 1234/1235
        run_op(1'b0, 1'b1, 3'd3, 16'hBEEF);        // ldar
        run_op(1'b0, 1'b1, 3'd7, 16'h5555);        // x_op 111 is a NOP
        run_op(1'b0, 1'b1, 3'd2, 16'hFFFF);        // PC wrap through fetch
        run_op(1'b1, 1'b0, 3'd7, 16'h0);
        run_streak();
        for (int n = 0; n < 40; n++) begin
            int mode;
            mode = int'($urandom_range(0, 2));
            run_op(mode != 0, mode != 1, 3'($urandom_range(0, 7)), 16'($urandom));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        run_reset_mid_push();
        run_op(1'b1, 1'b0, 3'd7, 16'h0);
        chk("queue_drained", 32'(expq.size()), 32'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule

// File: doc/arf_controller.md
# arf_controller

Sequencer and arbiter for the address register file (PC, AR, SP). It grants the register file to two requesters: the fetch unit and the execute unit. It then drives the register file's FunSel/RegSel/OutCSel/OutDSel controls through multi-cycle fetch, push, pop, jump and AR-load sequences, and strobes a memory-address-valid signal while OutD carries a live memory address. It sits between the control unit and the address register file, which stays a pure datapath.

## Interface
- STREAK_MAX, 3: consecutive execute grants allowed while a fetch request waits.
- Clock  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- f_req  in  1  fetch request; held high until f_done.
- x_req  in  1  execute request; held high, with x_op stable, until x_done.
- x_op  in  3  000 PUSH, 001 POP, 010 JUMP (PC←I), 011 LDAR (AR←I), others NOP.
- FunSel  out  3  register function: 000 DEC, 001 INC, 010 LOAD, 011 CLEAR.
- RegSel  out  3  active-low enables: bit2 PC, bit1 AR, bit0 SP.
- OutCSel  out  2  always 00.
- OutDSel  out  2  00 PC, 10 AR, 11 SP.
- addr_vld  out  1  OutD holds a valid memory address this cycle.
- f_done  out  1  one-cycle pulse when fetch completes.
- x_done  out  1  one-cycle pulse when execute op completes.
- busy  out  1  high in every state except IDLE.

## Operation
- States: INIT, IDLE, F1, F2, PSH_DEC, PSH_WR, POP_RD, POP_INC, JMP, LDAR, XNOP.
- Outputs are a Moore decode of the registered state. Default per cycle: FunSel 000, RegSel 111, OutDSel 00, addr_vld 0, done 0.
- INIT: RegSel 000, FunSel CLEAR. Clears PC, AR and SP to 0. Goes to IDLE next.
- IDLE: arbitrates. x_req wins over f_req unless streak==STREAK_MAX and f_req=1; then fetch wins. No request: stay in IDLE.
- Streak counter (2 bits):
  - Increments on each execute grant while f_req=1, saturating at STREAK_MAX.
  - Clears on any fetch grant, or in any IDLE cycle with f_req=0.
- Fetch: F1 and F2, two bytes.
  - Each state: OutDSel 00, addr_vld 1, RegSel 011, FunSel INC.
  - OutD shows the pre-increment PC.
  - f_done is asserted in F2.
- PUSH (pre-decrement):
  - PSH_DEC: RegSel 110, FunSel DEC, addr_vld 0.
  - PSH_WR: OutDSel 11, addr_vld 1, no enables, x_done.
- POP (post-increment):
  - POP_RD: OutDSel 11, addr_vld 1, no enables.
  - POP_INC: RegSel 110, FunSel INC, x_done.
- JMP: RegSel 011, FunSel LOAD, x_done.
- LDAR: RegSel 101, FunSel LOAD, x_done.
- XNOP: no enables, x_done.
- Every final state returns to IDLE. Requests are sampled only in IDLE.
- Requests dropped mid-sequence do not abort the sequence.
- Width rules:
  - PC, AR and SP wrap modulo 2^16 (handled by the register file).
  - SP 0x0000 DEC yields 0xFFFF.
  - PC 0xFFFF INC yields 0x0000.
  - Neither wrap is flagged.

## Timing
- Reset asserted: state goes to INIT asynchronously. Outputs take the INIT values RegSel 000, FunSel 011, OutCSel 00, OutDSel 00, addr_vld 0, f_done 0, x_done 0, busy 1. The streak counter clears.
- Reset mid-sequence: abandons the sequence with no done pulse. The register file is re-cleared in INIT.
- First request can be granted in the IDLE cycle after INIT.
- Request present in IDLE at edge k: first op cycle is k to k+1.
- Latency from request to done:
  - Fetch: 2 cycles after IDLE.
  - PUSH and POP: 2 cycles after IDLE.
  - JMP, LDAR and NOP: 1 cycle after IDLE.
- Back-to-back operations always have one IDLE cycle between them.
- A requester seeing done must deassert, or change x_op, before the next IDLE sample. A still-high request is treated as a new request.
- f_req and x_req rising in the same IDLE cycle: execute is granted, and the streak becomes 1.

## Structure
- Package arf_ctrl_pkg holds:
  - FunSel codes.
  - RegSel masks (PC_EN 011, AR_EN 101, SP_EN 110, NONE 111, ALL 000).
  - OutSel codes.
  - x_op codes.
  - State enum.
- Sub-module arf_arbiter: IDLE grant decision plus the streak counter. Its inputs are f_req, x_req and idle. Its outputs are grant_f and grant_x.
- The top level holds the FSM and the output decode. The bench instantiates the address register file alongside it.

## Test plan
- Reset, then f_req for one fetch:
  - addr_vld in F1 with OutD 0x0000, and in F2 with OutD 0x0001.
  - f_done pulses in F2; PC is 0x0002 afterwards.
- From reset, PUSH: PSH_WR shows OutD 0xFFFF with addr_vld, and SP is 0xFFFF. A following POP shows OutD 0xFFFF in POP_RD and leaves SP at 0x0000.
- JUMP with I=0x1234, then fetch: PC is 0x1234, fetch addresses are 0x1234 and 0x1235, and PC ends at 0x1236. LDAR with I=0xBEEF: AR is 0xBEEF and PC is unchanged.
- f_req and x_req held high continuously (x_op NOP): grant order is X, X, X, F, X, X, X, F. Each x_done and f_done is a single-cycle pulse.
- Reset asserted in PSH_WR with SP 0xFFFF: immediately INIT, no x_done, and PC, AR and SP all 0 after one edge.
- x_op 111: XNOP with RegSel 111 and an x_done pulse, with no register change.
